// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard unit with a per-register countdown scoreboard for multi-cycle loads.
// Optional stall-cycle counter enabled by defining STALL_COUNT_EN.

module hazard_scoreboard_entry #(
  parameter int             SBW  = 1,
  parameter logic [SBW-1:0] INIT = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic pending
);
  logic [SBW-1:0] cnt;

  // A fresh load restarts the countdown even if one is already running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (load)           cnt <= INIT;
    else if (cnt != '0)      cnt <= cnt - SBW'(1);
  end

  assign pending = |cnt;
endmodule

module hazard_scoreboard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ID_EXmemRead,
  input  logic                ID_EXvalid,
  input  logic [REG_AW-1:0]   ID_EXrd,
  input  logic [REG_AW-1:0]   IF_IDrs1,
  input  logic [REG_AW-1:0]   IF_IDrs2,
  input  logic                IF_IDuseRs1,
  input  logic                IF_IDuseRs2,
  input  logic                branchTaken,
  output logic                PCwrite,
  output logic                IF_IDwrite,
  output logic                ID_EXwrite,
  output logic                regWrite,
  output logic                memWrite,
  output logic                IF_IDflush,
  output logic                stallActive,
  output logic [STALL_CW-1:0] stallCycles
);
  localparam int             NREG    = 2**REG_AW;
  localparam int             SBW     = $clog2(LOAD_LAT + 1);
  localparam logic [SBW-1:0] SB_INIT = SBW'(LOAD_LAT - 1);

  logic            ld_live;
  logic [NREG-1:0] load_hit;
  logic [NREG-1:0] pending;
  logic            busy1, busy2, hazard, stall;

  // x0 is never a real destination, so it is excluded from tracking entirely.
  assign ld_live = ID_EXvalid && ID_EXmemRead && (ID_EXrd != '0);

  assign load_hit[0] = 1'b0;
  assign pending[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    assign load_hit[r] = ld_live && (ID_EXrd == REG_AW'(r));
    hazard_scoreboard_entry #(.SBW(SBW), .INIT(SB_INIT)) u_ent (
      .clk     (clk),
      .reset   (reset),
      .load    (load_hit[r]),
      .pending (pending[r])
    );
  end

  assign busy1  = load_hit[IF_IDrs1] || pending[IF_IDrs1];
  assign busy2  = load_hit[IF_IDrs2] || pending[IF_IDrs2];
  assign hazard = (IF_IDuseRs1 && busy1) || (IF_IDuseRs2 && busy2);
  assign stall  = hazard && !branchTaken;

  always_comb begin
    PCwrite    = 1'b1;
    IF_IDwrite = 1'b1;
    ID_EXwrite = 1'b1;
    regWrite   = 1'b1;
    memWrite   = 1'b1;
    IF_IDflush = 1'b0;
    if (reset) begin
      if (branchTaken) begin
        // Flush squashes the stalled instruction, so it beats the hazard.
        IF_IDflush = 1'b1;
        ID_EXwrite = 1'b0;
        regWrite   = 1'b0;
        memWrite   = 1'b0;
      end else if (hazard) begin
        PCwrite    = 1'b0;
        IF_IDwrite = 1'b0;
        ID_EXwrite = 1'b0;
        regWrite   = 1'b0;
        memWrite   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stallActive <= 1'b0;
    else        stallActive <= stall;
  end

`ifdef STALL_COUNT_EN
  logic [STALL_CW-1:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CW'(1);
  end

  assign stallCycles = stall_cnt;
`else
  assign stallCycles = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: three instances (LOAD_LAT 1/2/3) share stimulus; each test
// starts from reset and checks the instance whose latency it targets.

module tb_hazard_scoreboard_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       mr, vld, u1, u2, br;
  logic [4:0] rd, rs1, rs2;

  wire [2:0]  pcw, ifw, idw, rw, mw, fl, sa;
  wire [15:0] sc0, sc2;
  wire [1:0]  sc1;

  int n_cmp = 0;
  int n_err = 0;

`ifdef STALL_COUNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(1), .STALL_CW(16)) u_l1 (
    .clk(clk), .reset(reset), .ID_EXmemRead(mr), .ID_EXvalid(vld), .ID_EXrd(rd),
    .IF_IDrs1(rs1), .IF_IDrs2(rs2), .IF_IDuseRs1(u1), .IF_IDuseRs2(u2), .branchTaken(br),
    .PCwrite(pcw[0]), .IF_IDwrite(ifw[0]), .ID_EXwrite(idw[0]), .regWrite(rw[0]),
    .memWrite(mw[0]), .IF_IDflush(fl[0]), .stallActive(sa[0]), .stallCycles(sc0));

  hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(2), .STALL_CW(2)) u_l2 (
    .clk(clk), .reset(reset), .ID_EXmemRead(mr), .ID_EXvalid(vld), .ID_EXrd(rd),
    .IF_IDrs1(rs1), .IF_IDrs2(rs2), .IF_IDuseRs1(u1), .IF_IDuseRs2(u2), .branchTaken(br),
    .PCwrite(pcw[1]), .IF_IDwrite(ifw[1]), .ID_EXwrite(idw[1]), .regWrite(rw[1]),
    .memWrite(mw[1]), .IF_IDflush(fl[1]), .stallActive(sa[1]), .stallCycles(sc1));

  hazard_scoreboard_unit #(.REG_AW(5), .LOAD_LAT(3), .STALL_CW(16)) u_l3 (
    .clk(clk), .reset(reset), .ID_EXmemRead(mr), .ID_EXvalid(vld), .ID_EXrd(rd),
    .IF_IDrs1(rs1), .IF_IDrs2(rs2), .IF_IDuseRs1(u1), .IF_IDuseRs2(u2), .branchTaken(br),
    .PCwrite(pcw[2]), .IF_IDwrite(ifw[2]), .ID_EXwrite(idw[2]), .regWrite(rw[2]),
    .memWrite(mw[2]), .IF_IDflush(fl[2]), .stallActive(sa[2]), .stallCycles(sc2));

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic v, input logic m, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic a1, input logic a2, input logic b);
    vld = v; mr = m; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; br = b;
  endtask

  task automatic rst();
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    // Hazard pattern applied while in reset: outputs must stay released.
    drv(1, 1, 5, 5, 0, 1, 0, 0);
    #3;
    chk("rst_pcw", pcw[0], 1);
    chk("rst_idw", idw[0], 1);
    chk("rst_mw",  mw[0],  1);
    chk("rst_fl",  fl[0],  0);
    chk("rst_sa",  sa[0],  0);
    chk("rst_sc",  sc1,    0);

    // LOAD_LAT=1: lw x5 / add x?,x5 -> exactly one bubble
    step(); rst();
    drv(1, 1, 5, 5, 0, 1, 0, 0); #2;
    chk("l1_pcw",  pcw[0], 0);
    chk("l1_ifw",  ifw[0], 0);
    chk("l1_idw",  idw[0], 0);
    chk("l1_rw",   rw[0],  0);
    chk("l1_mw",   mw[0],  0);
    chk("l1_fl",   fl[0],  0);
    step();
    chk("l1_sa1",  sa[0],  1);
    drv(0, 1, 5, 5, 0, 1, 0, 0); #2;
    chk("l1_rel_pcw", pcw[0], 1);
    chk("l1_rel_idw", idw[0], 1);
    step();
    chk("l1_sa0",  sa[0],  0);

    // LOAD_LAT=3: lw x7 then rs2=7 held -> 3 stall cycles
    step(); rst();
    drv(1, 1, 7, 0, 7, 0, 1, 0); #2;
    chk("l3_c0_pcw", pcw[2], 0);
    step();
    drv(0, 0, 0, 0, 7, 0, 1, 0); #2;
    chk("l3_c1_pcw", pcw[2], 0);
    chk("l3_c1_sa",  sa[2],  1);
    chk("l1_c1_pcw", pcw[0], 1);
    step(); #2;
    chk("l3_c2_ifw", ifw[2], 0);
    step(); #2;
    chk("l3_c3_pcw", pcw[2], 1);
    chk("l3_c3_idw", idw[2], 1);
    step();
    chk("l3_c4_sa",  sa[2],  0);

    // x0 destination and per-operand use flags
    step(); rst();
    drv(1, 1, 0, 0, 0, 1, 1, 0); #2;
    chk("x0_pcw", pcw[2], 1);
    step();
    drv(0, 0, 0, 0, 0, 1, 1, 0); #2;
    chk("x0_sb_pcw", pcw[2], 1);
    step();
    drv(1, 1, 9, 0, 9, 1, 0, 0); #2;
    chk("use2off_pcw", pcw[2], 1);
    step();
    drv(0, 0, 0, 9, 0, 1, 0, 0); #2;
    chk("sb9_rs1_pcw", pcw[2], 0);

    // Taken branch coinciding with a load-use hazard
    step(); rst();
    drv(1, 1, 5, 5, 0, 1, 0, 1); #2;
    chk("br_fl",  fl[0],  1);
    chk("br_pcw", pcw[0], 1);
    chk("br_ifw", ifw[0], 1);
    chk("br_idw", idw[0], 0);
    chk("br_rw",  rw[0],  0);
    chk("br_mw",  mw[0],  0);
    step();
    chk("br_sa",  sa[0],  0);
    drv(0, 0, 0, 5, 0, 1, 0, 0); #2;
    chk("br_ld_kept_pcw", pcw[2], 0);

    // Asynchronous reset in the middle of a LOAD_LAT=3 stall
    step(); rst();
    drv(1, 1, 7, 0, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 7, 0, 1, 0, 0); #2;
    chk("mid_pre_pcw", pcw[2], 0);
    reset = 1'b0; #1;
    chk("mid_rst_pcw", pcw[2], 1);
    chk("mid_rst_ifw", ifw[2], 1);
    chk("mid_rst_idw", idw[2], 1);
    reset = 1'b1; #1;
    chk("mid_post_pcw", pcw[2], 1);
    step();
    chk("mid_post_sa",  sa[2],  0);

    // Five load-use pairs on LOAD_LAT=2 with a 2-bit counter
    step(); rst();
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 3, 3, 0, 1, 0, 0); #2;
      chk("cnt_ld_pcw", pcw[1], 0);
      step();
      drv(0, 0, 0, 3, 0, 1, 0, 0); #2;
      chk("cnt_sb_pcw", pcw[1], 0);
      step();
      if (i == 0) chk("cnt_first", sc1, EN ? 2 : 0);
    end
    drv(0, 0, 0, 3, 0, 1, 0, 0); #2;
    chk("cnt_l2_rel",  pcw[1], 1);
    chk("cnt_sat",     sc1,    EN ? 3 : 0);
    chk("cnt_l3_10",   sc2,    EN ? 10 : 0);
    chk("cnt_l1_5",    sc0,    EN ? 5 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
